// File: rtl/fft_output_reorder.sv
// fft_output_reorder: natural-order reorder buffer at the output of the 32-point SDF FFT.
// Incoming samples arrive in bit-reversed frequency order. Each frame is written into one
// half of a ping-pong buffer at bit-reversed addresses. It is then read back sequentially,
// so the output comes out in natural order X[0]..X[N-1] at one sample per cycle.
// Optional feature: define REORDER_BYPASS_EN to add bypass_i. While bypass_i is high,
// the reorder buffer is bypassed and inputs are registered straight to the outputs.
module fft_output_reorder #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LOG2N  = 5,
    parameter int unsigned N      = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_i,
    input  logic                     sof_i,
    input  logic signed [DATA_W-1:0] data_in_r,
    input  logic signed [DATA_W-1:0] data_in_i,
`ifdef REORDER_BYPASS_EN
    input  logic                     bypass_i,
`endif
    output logic                     valid_o,
    output logic                     sof_o,
    output logic signed [DATA_W-1:0] data_out_r,
    output logic signed [DATA_W-1:0] data_out_i
);

    localparam int unsigned SW = 2 * DATA_W;
    localparam int unsigned AW = LOG2N + 1;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    // Mirror the bit order of an index within LOG2N bits.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int b = 0; b < int'(LOG2N); b++) begin
            r[b] = a[int'(LOG2N) - 1 - b];
        end
        return r;
    endfunction

    logic [SW-1:0]    mem [2*N];
    logic [LOG2N-1:0] wcnt;
    logic             wbank;
    logic [1:0]       full;
    state_t           state;
    logic             rbank;
    logic [LOG2N-1:0] rcnt;

    logic             bypass_c;
    logic             wr_en_c;
    logic [LOG2N-1:0] wr_addr_c;
    logic             complete_c;
    logic             rd_en_c;
    logic             rd_bank_c;
    logic [LOG2N-1:0] rd_addr_c;
    logic             rd_last_c;
    logic             other_ready_c;
    logic [SW-1:0]    rd_word_c;

`ifdef REORDER_BYPASS_EN
    assign bypass_c = bypass_i;
`else
    assign bypass_c = 1'b0;
`endif

    // Write side. A sof forces arrival index 0, and a write at index N-1 completes the frame.
    assign wr_en_c    = valid_i && !bypass_c;
    assign wr_addr_c  = sof_i ? '0 : bitrev(wcnt);
    assign complete_c = wr_en_c && !sof_i && (wcnt == LAST);

    // Read selection. A finished bank starts the reader. So does a bank that finishes on this
    // very edge, so that the first output appears one cycle after the last input.
    always_comb begin
        rd_en_c   = 1'b0;
        rd_bank_c = rbank;
        rd_addr_c = rcnt;
        if (!bypass_c) begin
            case (state)
                S_IDLE: begin
                    rd_addr_c = '0;
                    if (full[0]) begin
                        rd_en_c   = 1'b1;
                        rd_bank_c = 1'b0;
                    end else if (full[1]) begin
                        rd_en_c   = 1'b1;
                        rd_bank_c = 1'b1;
                    end else if (complete_c) begin
                        rd_en_c   = 1'b1;
                        rd_bank_c = wbank;
                    end
                end
                S_READ: begin
                    rd_en_c = 1'b1;
                end
                default: begin
                    rd_en_c = 1'b0;
                end
            endcase
        end
    end

    assign rd_last_c     = rd_en_c && (rd_addr_c == LAST);
    assign other_ready_c = full[~rd_bank_c] || (complete_c && (wbank != rd_bank_c));
    assign rd_word_c     = mem[{rd_bank_c, rd_addr_c}];

    // Sample storage. It is not reset, because its contents are only read after a full frame.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[AW'({wbank, wr_addr_c})] <= {data_in_r, data_in_i};
        end
    end

    // Write counter and write-bank toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt  <= '0;
            wbank <= 1'b0;
        end else if (bypass_c) begin
            wcnt  <= '0;
            wbank <= 1'b0;
        end else if (wr_en_c) begin
            if (sof_i) begin
                wcnt <= LOG2N'(1);
            end else if (complete_c) begin
                wcnt  <= '0;
                wbank <= ~wbank;
            end else begin
                wcnt <= wcnt + LOG2N'(1);
            end
        end
    end

    // Bank-full flags. The writer sets a flag on frame completion; the reader clears it after its last read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else if (bypass_c) begin
            full <= '0;
        end else begin
            if (complete_c) begin
                full[wbank] <= 1'b1;
            end
            if (rd_last_c) begin
                full[rd_bank_c] <= 1'b0;
            end
        end
    end

    // Reader FSM. It walks rcnt over one bank and then hops to the other bank without a bubble if that bank is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rbank <= 1'b0;
            rcnt  <= '0;
        end else if (bypass_c) begin
            state <= S_IDLE;
            rbank <= 1'b0;
            rcnt  <= '0;
        end else if (rd_en_c) begin
            state <= S_READ;
            rbank <= rd_bank_c;
            if (rd_last_c) begin
                rcnt <= '0;
                if (other_ready_c) begin
                    rbank <= ~rd_bank_c;
                end else begin
                    state <= S_IDLE;
                end
            end else begin
                rcnt <= rd_addr_c + LOG2N'(1);
            end
        end
    end

    // Registered outputs. The data registers hold their value whenever no sample is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o    <= 1'b0;
            sof_o      <= 1'b0;
            data_out_r <= '0;
            data_out_i <= '0;
        end else if (bypass_c) begin
            valid_o <= valid_i;
            sof_o   <= valid_i && sof_i;
            if (valid_i) begin
                data_out_r <= data_in_r;
                data_out_i <= data_in_i;
            end
        end else if (rd_en_c) begin
            valid_o    <= 1'b1;
            sof_o      <= (rd_addr_c == '0);
            data_out_r <= rd_word_c[SW-1:DATA_W];
            data_out_i <= rd_word_c[DATA_W-1:0];
        end else begin
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench for fft_output_reorder. The reference model collects each frame in
// arrival order. When the frame completes, the model emits X[n] = frame[bitrev(n)].
// Each expected sample carries the edge number at which it is due.
`timescale 1ns/1ps
module tb_fft_output_reorder;

    localparam int DATA_W = 16;
    localparam int LOG2N  = 5;
    localparam int N      = 32;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     valid_i = 1'b0;
    logic                     sof_i = 1'b0;
    logic signed [DATA_W-1:0] data_in_r = '0;
    logic signed [DATA_W-1:0] data_in_i = '0;
    logic                     valid_o;
    logic                     sof_o;
    logic signed [DATA_W-1:0] data_out_r;
    logic signed [DATA_W-1:0] data_out_i;
`ifdef REORDER_BYPASS_EN
    logic                     bypass_i = 1'b0;
`endif

    fft_output_reorder #(.DATA_W(DATA_W), .LOG2N(LOG2N), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .sof_i      (sof_i),
        .data_in_r  (data_in_r),
        .data_in_i  (data_in_i),
`ifdef REORDER_BYPASS_EN
        .bypass_i   (bypass_i),
`endif
        .valid_o    (valid_o),
        .sof_o      (sof_o),
        .data_out_r (data_out_r),
        .data_out_i (data_out_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                       cyc;
        logic signed [DATA_W-1:0] r;
        logic signed [DATA_W-1:0] i;
        logic                     sof;
    } exp_t;

    exp_t                     q[$];
    exp_t                     mon_e;
    int                       errors = 0;
    int                       checks = 0;
    int                       cyc = 0;
    int                       k = 0;
    bit                       bypass_mode = 1'b0;
    logic signed [DATA_W-1:0] fr_r [N];
    logic signed [DATA_W-1:0] fr_i [N];
    logic signed [DATA_W-1:0] last_r = '0;
    logic signed [DATA_W-1:0] last_i = '0;

    always @(posedge clk) cyc++;

    function automatic int bitrev(input int n);
        int res = 0;
        for (int b = 0; b < LOG2N; b++) begin
            if (((n >> b) & 1) != 0) res += 1 << (LOG2N - 1 - b);
        end
        return res;
    endfunction

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one cycle of input and update the reference model once the edge has captured it.
    task automatic send(input logic v, input logic s,
                        input logic signed [DATA_W-1:0] r, input logic signed [DATA_W-1:0] im);
        exp_t e;
        valid_i = v; sof_i = s; data_in_r = r; data_in_i = im;
        @(posedge clk); #1;
        if (v) begin
            if (bypass_mode) begin
                e.cyc = cyc; e.r = r; e.i = im; e.sof = s;
                q.push_back(e);
            end else begin
                if (s) k = 0;
                fr_r[k] = r; fr_i[k] = im;
                k++;
                if (k == N) begin
                    for (int n = 0; n < N; n++) begin
                        e.cyc = cyc + n; e.r = fr_r[bitrev(n)]; e.i = fr_i[bitrev(n)]; e.sof = (n == 0);
                        q.push_back(e);
                    end
                    k = 0;
                end
            end
        end
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++)
            send(1'b0, 1'($urandom_range(0, 1)), DATA_W'($urandom), DATA_W'($urandom));
    endtask

    task automatic rand_frame(input int gap_pct);
        int sent = 0;
        while (sent < N) begin
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                send(1'b0, 1'($urandom_range(0, 1)), DATA_W'($urandom), DATA_W'($urandom));
            end else begin
                send(1'b1, sent == 0, DATA_W'($urandom), DATA_W'($urandom));
                sent++;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        k = 0; last_r = '0; last_i = '0;
        valid_i = 1'b0; sof_i = 1'b0;
        #1;
        chk("reset_valid_o", valid_o, 0);
        chk("reset_sof_o", sof_o, 0);
        chk("reset_data_r", data_out_r, 0);
        chk("reset_data_i", data_out_i, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: it compares every presented sample against the head of the scoreboard, including the edge at which the sample is due.
    always @(negedge clk) begin
        if (rst_n === 1'b0) begin
            chk("in_reset_valid_o", valid_o, 0);
        end else if (rst_n === 1'b1) begin
            if (valid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", valid_o, 0);
                end else begin
                    mon_e = q[0];
                    q.delete(0);
                    chk("out_edge", cyc, mon_e.cyc);
                    chk("out_r", data_out_r, mon_e.r);
                    chk("out_i", data_out_i, mon_e.i);
                    chk("out_sof", sof_o, mon_e.sof);
                    last_r = mon_e.r; last_i = mon_e.i;
                end
            end else begin
                chk("idle_sof_o", sof_o, 0);
                chk("hold_r", data_out_r, last_r);
                chk("hold_i", data_out_i, last_i);
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    chk("missing_output", valid_o, 1);
                    q.delete(0);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        #2;
        do_reset();

        // Single frame with a ramp: the output is expected as bitrev(n) and its negation.
        for (int i = 0; i < N; i++) send(1'b1, i == 0, DATA_W'(i), DATA_W'(-i));
        idle(40);

        // Three back-to-back frames with continuous valid.
        repeat (3) rand_frame(0);
        idle(40);

        // Frame with 50% gaps in valid.
        rand_frame(50);
        idle(40);

        // Restart mid-frame: the 10-sample partial frame must never appear at the output.
        for (int i = 0; i < 10; i++) send(1'b1, i == 0, DATA_W'($urandom), DATA_W'($urandom));
        rand_frame(0);
        idle(40);

        // Reset while output index 12 is on the port, then a clean frame.
        rand_frame(0);
        idle(12);
        do_reset();
        for (int i = 0; i < N; i++) send(1'b1, i == 0, DATA_W'(3 * i + 1), DATA_W'(-7 * i));
        idle(40);

        // Mixed random traffic, frames back to back with light gaps.
        repeat (4) rand_frame(25);
        idle(40);

`ifdef REORDER_BYPASS_EN
        bypass_i = 1'b1; bypass_mode = 1'b1;
        send(1'b1, 1'b1, DATA_W'(5), DATA_W'(-5));
        send(1'b1, 1'b0, DATA_W'(6), DATA_W'(-6));
        send(1'b1, 1'b0, DATA_W'(7), DATA_W'(-7));
        idle(3);
        bypass_i = 1'b0; bypass_mode = 1'b0; k = 0;
        rand_frame(0);
        idle(40);
`endif

        // Drain with a bound on the wait.
        for (int c = 0; c < 200 && q.size() > 0; c++) idle(1);
        chk("drain_queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
